// File: rtl/hazard_forward_ctrl_if.sv
// rtl/hazard_forward_ctrl_if.sv - pipeline-side bundle for the hazard/forward controller
interface hazard_forward_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             ihit;
    logic             dhit;
    logic             dmemreq_ex_mem;
    logic [4:0]       rs_if_id;
    logic [4:0]       rt_if_id;
    logic [4:0]       rd_id_ex;
    logic             regwen_id_ex;
    logic             memread_id_ex;
    logic             lui_id_ex;
    logic [4:0]       rd_ex_mem;
    logic             regwen_ex_mem;
    logic             branch_taken_ex;
    logic             halt_mem_wb;
    logic [2:0]       forwarda;
    logic [2:0]       forwardb;
    logic             pc_en;
    logic             if_id_en;
    logic             id_ex_en;
    logic             ex_mem_en;
    logic             mem_wb_en;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic [CNT_W-1:0] stall_count;

    // Pipeline datapath side: reports hazard sources, consumes enables/selects.
    modport master (
        output ihit, dhit, dmemreq_ex_mem, rs_if_id, rt_if_id, rd_id_ex,
               regwen_id_ex, memread_id_ex, lui_id_ex, rd_ex_mem,
               regwen_ex_mem, branch_taken_ex, halt_mem_wb,
        input  forwarda, forwardb, pc_en, if_id_en, id_ex_en, ex_mem_en,
               mem_wb_en, if_id_flush, id_ex_flush, stall_count
    );

    // Controller side.
    modport slave (
        input  ihit, dhit, dmemreq_ex_mem, rs_if_id, rt_if_id, rd_id_ex,
               regwen_id_ex, memread_id_ex, lui_id_ex, rd_ex_mem,
               regwen_ex_mem, branch_taken_ex, halt_mem_wb,
        output forwarda, forwardb, pc_en, if_id_en, id_ex_en, ex_mem_en,
               mem_wb_en, if_id_flush, id_ex_flush, stall_count
    );
endinterface

// File: rtl/hazard_forward_ctrl.sv
// rtl/hazard_forward_ctrl.sv - 5-stage pipeline stall/flush/forward controller
module hazard_forward_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    hazard_forward_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [2:0] FWD_RF    = 3'b000;
    localparam logic [2:0] FWD_ALU   = 3'b001;
    localparam logic [2:0] FWD_WB    = 3'b010;
    localparam logic [2:0] FWD_UPPER = 3'b011;

    state_t           state_q, state_d;
    logic [2:0]       forwarda_q, forwarda_d;
    logic [2:0]       forwardb_q, forwardb_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_flush, id_ex_flush;
    logic dmiss, load_use;

    // Youngest producer wins; register 0 is never a forwarding source.
    function automatic logic [2:0] fwd_sel(input logic [4:0] src);
        if (bus.regwen_id_ex && bus.rd_id_ex != 5'd0 && bus.rd_id_ex == src)
            return bus.lui_id_ex ? FWD_UPPER : FWD_ALU;
        else if (bus.regwen_ex_mem && bus.rd_ex_mem != 5'd0 && bus.rd_ex_mem == src)
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

    assign dmiss    = bus.dmemreq_ex_mem && !bus.dhit;
    assign load_use = bus.memread_id_ex && bus.regwen_id_ex && (bus.rd_id_ex != 5'd0) &&
                      ((bus.rd_id_ex == bus.rs_if_id) || (bus.rd_id_ex == bus.rt_if_id));

    // Latch enables and bubble inserts, highest-priority hazard first.
    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (RST || state_q == HALT || bus.halt_mem_wb || dmiss) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else if (bus.branch_taken_ex) begin
            // Redirect regardless of ihit; kill both wrong-path instrs.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end else if (!bus.ihit) begin
            pc_en       = 1'b0;
            if_id_flush = 1'b1;
        end
    end

    // Next state, forward selects and stall counter.
    always_comb begin
        state_d       = state_q;
        forwarda_d    = forwarda_q;
        forwardb_d    = forwardb_q;
        stall_count_d = stall_count_q;

        if (bus.halt_mem_wb) begin
            state_d = HALT;
        end else begin
            case (state_q)
                RUN:     if (dmiss) state_d = DWAIT;
                DWAIT:   if (bus.dhit) state_d = RUN;
                HALT:    state_d = HALT;
                default: state_d = RUN;
            endcase
        end

        // Selects travel with the instr moving into EX, so they follow id_ex_en.
        if (id_ex_en) begin
            forwarda_d = id_ex_flush ? FWD_RF : fwd_sel(bus.rs_if_id);
            forwardb_d = id_ex_flush ? FWD_RF : fwd_sel(bus.rt_if_id);
        end

        if (!pc_en && state_q != HALT && stall_count_q != {CNT_W{1'b1}})
            stall_count_d = stall_count_q + 1'b1;
    end

    // State register with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= RUN;
            forwarda_q    <= FWD_RF;
            forwardb_q    <= FWD_RF;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            forwarda_q    <= forwarda_d;
            forwardb_q    <= forwardb_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign bus.forwarda    = forwarda_q;
    assign bus.forwardb    = forwardb_q;
    assign bus.stall_count = stall_count_q;
    assign bus.pc_en       = pc_en;
    assign bus.if_id_en    = if_id_en;
    assign bus.id_ex_en    = id_ex_en;
    assign bus.ex_mem_en   = ex_mem_en;
    assign bus.mem_wb_en   = mem_wb_en;
    assign bus.if_id_flush = if_id_flush;
    assign bus.id_ex_flush = id_ex_flush;
endmodule
